// File: rtl/sha_host_bridge_pkg.sv
// Shared definitions for the SHA host bridge: FSM states, beat/index
// width helpers and the legal external bus widths.
package sha_host_bridge_pkg;

    localparam int unsigned BUS_W_8  = 8;
    localparam int unsigned BUS_W_16 = 16;
    localparam int unsigned BUS_W_32 = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Number of bus beats needed to assemble one core word.
    function automatic int unsigned beats(input int unsigned bus_w, input int unsigned word_w);
        return word_w / bus_w;
    endfunction

    // Width of a counter indexing n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit bus_w_legal(input int unsigned w);
        return (w == BUS_W_8) || (w == BUS_W_16) || (w == BUS_W_32);
    endfunction

endpackage

// File: rtl/sha_lz_count.sv
// Combinational leading-zero counter, MSB-first. An all-zero value
// yields W.
module sha_lz_count #(
    parameter  int unsigned W  = 256,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Scan upward so the highest set bit is the last one to write count.
    always_comb begin
        count = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/sha_host_bridge.sv
// SHA host bridge: starts the hash core, serves its word requests by
// assembling WORD_W words from BUS_W-wide external reads, and drains the
// finished digest to the host one byte at a time, MSB-first.
// Optional build macro TARGET_CMP_EN adds lz_target/hit, a leading-zero
// target comparison registered when the digest is latched.
module sha_host_bridge
    import sha_host_bridge_pkg::*;
#(
    parameter  int unsigned BUS_W        = 16,
    parameter  int unsigned WORD_W       = 32,
    parameter  int unsigned ADDR_W       = 5,
    parameter  int unsigned DIGEST_BYTES = 32,
    localparam int unsigned BEATS        = beats(BUS_W, WORD_W),
    localparam int unsigned LOG_BEATS    = $clog2(BEATS),
    localparam int unsigned BEAT_W       = idx_w(BEATS),
    localparam int unsigned IDX_W        = idx_w(DIGEST_BYTES),
    localparam int unsigned DIG_W        = 8 * DIGEST_BYTES,
    localparam int unsigned BUS_ADDR_W   = ADDR_W + LOG_BEATS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BUS_W-1:0]      bus_in,
    output logic [BUS_ADDR_W-1:0] bus_addr,
    output logic                  bus_rd,
    output logic                  core_start,
    input  logic                  core_word_rq,
    input  logic [ADDR_W-1:0]     core_word_addr,
    output logic [WORD_W-1:0]     core_word,
    output logic                  core_word_vld,
    input  logic                  core_done,
    input  logic [DIG_W-1:0]      core_digest,
    output logic [7:0]            out_byte,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_vld,
    input  logic                  out_ack,
`ifdef TARGET_CMP_EN
    input  logic [7:0]            lz_target,
    output logic                  hit,
`endif
    output logic                  busy,
    output logic                  done
);

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       word_addr;
    logic [BEAT_W-1:0]       beat;
    logic [DIG_W-1:0]        digest;
    logic [BUS_ADDR_W-1:0]   addr_cat;
    logic [DIG_W-1:0]        digest_shifted;

    logic go_start, go_fetch, go_digest, do_beat, fetch_end, do_ack, drain_end;

    if (LOG_BEATS == 0) begin : g_single_beat
        assign addr_cat = word_addr;
    end else begin : g_multi_beat
        assign addr_cat = {word_addr, beat};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode, datapath strobes and state-derived outputs.
    always_comb begin
        state_nxt = state;
        go_start  = 1'b0;
        go_fetch  = 1'b0;
        go_digest = 1'b0;
        do_beat   = 1'b0;
        fetch_end = 1'b0;
        do_ack    = 1'b0;
        drain_end = 1'b0;
        bus_rd    = 1'b0;
        bus_addr  = '0;
        out_vld   = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    go_start  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A finished digest takes priority over a pending word request.
                if (core_done) begin
                    go_digest = 1'b1;
                    state_nxt = ST_DRAIN;
                end else if (core_word_rq && !core_word_vld) begin
                    go_fetch  = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                do_beat  = 1'b1;
                bus_rd   = 1'b1;
                bus_addr = addr_cat;
                if (beat == BEAT_W'(BEATS - 1)) begin
                    fetch_end = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                out_vld = 1'b1;
                if (out_ack) begin
                    do_ack = 1'b1;
                    if (out_idx == IDX_W'(DIGEST_BYTES - 1)) begin
                        drain_end = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: pulses, fetch address/beat, word assembly, digest and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_start    <= 1'b0;
            core_word_vld <= 1'b0;
            core_word     <= '0;
            word_addr     <= '0;
            beat          <= '0;
            digest        <= '0;
            out_idx       <= '0;
            done          <= 1'b0;
        end else begin
            core_start    <= go_start;
            core_word_vld <= fetch_end;
            if (go_start)  done <= 1'b0;
            if (drain_end) done <= 1'b1;
            if (go_fetch) begin
                word_addr <= core_word_addr;
                beat      <= '0;
            end else if (do_beat) begin
                beat <= fetch_end ? '0 : beat + 1'b1;
            end
            if (do_beat) core_word[beat*BUS_W +: BUS_W] <= bus_in;
            if (go_digest) begin
                digest  <= core_digest;
                out_idx <= '0;
            end else if (do_ack) begin
                out_idx <= drain_end ? '0 : out_idx + 1'b1;
            end
        end
    end

    // Byte select: shifting left by 8*out_idx brings the wanted byte to the top.
    always_comb begin
        digest_shifted = digest << {out_idx, 3'b000};
        out_byte       = out_vld ? digest_shifted[DIG_W-1 -: 8] : 8'h00;
    end

`ifdef TARGET_CMP_EN
    localparam int unsigned LZ_W = $clog2(DIG_W + 1);
    logic [LZ_W-1:0] lz;

    sha_lz_count #(.W(DIG_W)) u_lz (
        .value (core_digest),
        .count (lz)
    );

    // Target hit, evaluated on the digest as it is latched; cleared by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         hit <= 1'b0;
        else if (go_start)  hit <= 1'b0;
        else if (go_digest) hit <= (32'(lz) >= 32'(lz_target));
    end
`endif

endmodule

// File: tb/tb_sha_host_bridge.sv
// Self-checking bench for sha_host_bridge: a 16-bit-bus instance for the
// full flow and an 8-bit-bus instance for narrow fetches, both checked
// against a memory/digest reference model.
module tb_sha_host_bridge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bit bus instance
    logic         start, core_word_rq, core_done, out_ack;
    logic [15:0]  bus_in;
    logic [5:0]   bus_addr;
    logic         bus_rd, core_start, core_word_vld, out_vld, busy, done;
    logic [4:0]   core_word_addr, out_idx;
    logic [31:0]  core_word;
    logic [255:0] core_digest;
    logic [7:0]   out_byte;
`ifdef TARGET_CMP_EN
    logic [7:0]   lz_target, n_lz_target;
    logic         hit, n_hit;
`endif

    // 8-bit bus instance
    logic         n_start, n_rq, n_core_done, n_out_ack;
    logic [7:0]   n_bus_in;
    logic [6:0]   n_bus_addr;
    logic         n_bus_rd, n_core_start, n_vld, n_out_vld, n_busy, n_done;
    logic [4:0]   n_addr_in, n_out_idx;
    logic [31:0]  n_core_word;
    logic [255:0] n_digest;
    logic [7:0]   n_out_byte;

    logic [15:0] mem16 [64];
    logic [7:0]  mem8  [128];
    assign bus_in   = mem16[bus_addr];
    assign n_bus_in = mem8[n_bus_addr];

    sha_host_bridge #(.BUS_W(16), .WORD_W(32), .ADDR_W(5), .DIGEST_BYTES(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus_in(bus_in), .bus_addr(bus_addr),
        .bus_rd(bus_rd), .core_start(core_start), .core_word_rq(core_word_rq),
        .core_word_addr(core_word_addr), .core_word(core_word), .core_word_vld(core_word_vld),
        .core_done(core_done), .core_digest(core_digest), .out_byte(out_byte),
        .out_idx(out_idx), .out_vld(out_vld), .out_ack(out_ack),
`ifdef TARGET_CMP_EN
        .lz_target(lz_target), .hit(hit),
`endif
        .busy(busy), .done(done)
    );

    sha_host_bridge #(.BUS_W(8), .WORD_W(32), .ADDR_W(5), .DIGEST_BYTES(32)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(n_start), .bus_in(n_bus_in), .bus_addr(n_bus_addr),
        .bus_rd(n_bus_rd), .core_start(n_core_start), .core_word_rq(n_rq),
        .core_word_addr(n_addr_in), .core_word(n_core_word), .core_word_vld(n_vld),
        .core_done(n_core_done), .core_digest(n_digest), .out_byte(n_out_byte),
        .out_idx(n_out_idx), .out_vld(n_out_vld), .out_ack(n_out_ack),
`ifdef TARGET_CMP_EN
        .lz_target(n_lz_target), .hit(n_hit),
`endif
        .busy(n_busy), .done(n_done)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: leading zeros counted MSB-first.
    function automatic int lz_ref(input logic [255:0] d);
        int n = 0;
        while (n < 256 && d[255-n] == 1'b0) n++;
        return n;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_bus_rd"}, bus_rd, 0);
        check_eq({tag, "_bus_addr"}, bus_addr, 0);
        check_eq({tag, "_core_start"}, core_start, 0);
        check_eq({tag, "_core_word"}, core_word, 0);
        check_eq({tag, "_word_vld"}, core_word_vld, 0);
        check_eq({tag, "_out_byte"}, out_byte, 0);
        check_eq({tag, "_out_idx"}, out_idx, 0);
        check_eq({tag, "_out_vld"}, out_vld, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_n_busy"}, n_busy, 0);
        check_eq({tag, "_n_word"}, n_core_word, 0);
`ifdef TARGET_CMP_EN
        check_eq({tag, "_hit"}, hit, 0);
`endif
    endtask

    task automatic do_start(input bit narrow);
        if (narrow) n_start = 1'b1; else start = 1'b1;
        tick();
        if (narrow) n_start = 1'b0; else start = 1'b0;
        check_eq("core_start", narrow ? n_core_start : core_start, 1);
        check_eq("start_busy", narrow ? n_busy : busy, 1);
        check_eq("start_done_clr", narrow ? n_done : done, 0);
`ifdef TARGET_CMP_EN
        if (!narrow) check_eq("hit_clear", hit, 0);
`endif
        tick();
        check_eq("core_start_pulse", narrow ? n_core_start : core_start, 0);
    endtask

    task automatic do_fetch(input bit narrow, input int addr);
        int unsigned nb = narrow ? 4 : 2;
        int unsigned bw = narrow ? 8 : 16;
        logic [31:0] exp_word = '0;
        int unsigned cyc = 0, seen = 0;
        bit got_vld = 1'b0;
        for (int unsigned b = 0; b < nb; b++)
            exp_word = exp_word | ((narrow ? 32'(mem8[addr*4+b]) : 32'(mem16[addr*2+b])) << (b*bw));
        if (narrow) begin n_rq = 1'b1; n_addr_in = 5'(addr); end
        else        begin core_word_rq = 1'b1; core_word_addr = 5'(addr); end
        while (cyc < 20 && !got_vld) begin
            tick();
            cyc++;
            if (narrow ? n_bus_rd : bus_rd) begin
                check_eq("bus_addr", narrow ? 32'(n_bus_addr) : 32'(bus_addr), addr*nb + seen);
                seen++;
            end
            if (narrow ? n_vld : core_word_vld) got_vld = 1'b1;
        end
        if (narrow) n_rq = 1'b0; else core_word_rq = 1'b0;
        check_eq("fetch_vld_seen", got_vld, 1);
        check_eq("fetch_latency", cyc, nb + 1);
        check_eq("fetch_beats", seen, nb);
        check_eq("core_word", narrow ? n_core_word : core_word, exp_word);
        tick();
        check_eq("vld_pulse", narrow ? n_vld : core_word_vld, 0);
        check_eq("bus_rd_idle", narrow ? n_bus_rd : bus_rd, 0);
        check_eq("word_hold", narrow ? n_core_word : core_word, exp_word);
    endtask

    // mode 0: ack every cycle; 1: random ack; 2: ack withheld 5 cycles at index 4.
    task automatic do_drain(input logic [255:0] d, input int mode, input bit with_rq);
        int idx = 0, cyc = 0, held = 0;
        bit ack;
        core_done = 1'b1;
        core_digest = d;
        if (with_rq) begin core_word_rq = 1'b1; core_word_addr = 5'($urandom); end
        tick();
        core_done = 1'b0;
        core_digest = rand256();
`ifdef TARGET_CMP_EN
        check_eq("hit", hit, (lz_ref(d) >= int'(lz_target)) ? 1 : 0);
`endif
        while (idx < 32 && cyc < 500) begin
            check_eq("out_vld", out_vld, 1);
            check_eq("out_idx", out_idx, idx);
            check_eq("out_byte", out_byte, (d >> (8*(31-idx))) & 256'hFF);
            check_eq("drain_bus_rd", bus_rd, 0);
            if (mode == 0) ack = 1'b1;
            else if (mode == 1) ack = 1'($urandom_range(0, 1));
            else if (idx == 4 && held < 5) begin ack = 1'b0; held++; end
            else ack = 1'b1;
            out_ack = ack;
            tick();
            cyc++;
            if (ack) idx++;
        end
        out_ack = 1'b0;
        core_word_rq = 1'b0;
        check_eq("drain_complete", idx, 32);
        check_eq("drain_done", done, 1);
        check_eq("drain_busy", busy, 0);
        check_eq("drain_out_vld", out_vld, 0);
        if (mode == 2) check_eq("withheld_cycles", held, 5);
    endtask

    initial begin
        logic [255:0] d;
        rst_n = 1'b0;
        start = 0; core_word_rq = 0; core_done = 0; out_ack = 0;
        core_word_addr = '0; core_digest = '0;
        n_start = 0; n_rq = 0; n_core_done = 0; n_out_ack = 0;
        n_addr_in = '0; n_digest = '0;
`ifdef TARGET_CMP_EN
        lz_target = 8'd0; n_lz_target = 8'd0;
`endif
        for (int i = 0; i < 64; i++)  mem16[i] = 16'($urandom);
        for (int i = 0; i < 128; i++) mem8[i]  = 8'($urandom);

        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Directed 16-bit fetch: 0xBEEF then 0xDEAD at bus addresses 6, 7.
        do_start(0);
        mem16[6] = 16'hBEEF;
        mem16[7] = 16'hDEAD;
        do_fetch(0, 3);
        check_eq("word_deadbeef", core_word, 32'hDEADBEEF);

        // start is ignored outside IDLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_ignored", core_start, 0);
        check_eq("still_busy", busy, 1);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 64; j++) mem16[j] = 16'($urandom);
            do_fetch(0, $urandom_range(0, 31));
        end

        // Narrow bus: four beats per word.
        do_start(1);
        do_fetch(1, 5);
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 128; j++) mem8[j] = 8'($urandom);
            do_fetch(1, $urandom_range(0, 31));
        end

        // Digest 0x00..01 with continuous ack.
        do_drain(256'h1, 0, 0);

        // Ack while not draining has no effect.
        out_ack = 1'b1;
        tick();
        tick();
        out_ack = 1'b0;
        check_eq("idle_ack_idx", out_idx, 0);
        check_eq("idle_ack_done", done, 1);
        check_eq("idle_ack_vld", out_vld, 0);

        // Ack withheld at index 4.
        do_start(0);
        do_drain(rand256(), 2, 0);

        // core_done and core_word_rq together: digest wins, no bus reads.
        do_start(0);
        do_drain(rand256(), 0, 1);

        for (int i = 0; i < 3; i++) begin
            do_start(0);
            do_fetch(0, $urandom_range(0, 31));
            do_drain(rand256(), 1, 0);
        end

`ifdef TARGET_CMP_EN
        d = rand256();
        d[255:232] = 24'h00007F;
        lz_target = 8'd17;
        do_start(0);
        do_drain(d, 0, 0);
        check_eq("hit_lz17", hit, 1);
        lz_target = 8'd18;
        do_start(0);
        do_drain(d, 0, 0);
        check_eq("hit_lz18", hit, 0);
        for (int i = 0; i < 3; i++) begin
            d = rand256() >> $urandom_range(0, 40);
            lz_target = 8'($urandom_range(0, 40));
            do_start(0);
            do_drain(d, 1, 0);
        end
`else
        d = '0;
        check_eq("digest_scratch", d, 0);
`endif

        // Reset asserted mid-fetch while beat 1 is on the bus.
        do_start(0);
        core_word_rq = 1'b1;
        core_word_addr = 5'd9;
        tick();
        tick();
        check_eq("mid_fetch_rd", bus_rd, 1);
        check_eq("mid_fetch_addr", bus_addr, 19);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        core_word_rq = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("post_reset");
        do_start(0);
        do_fetch(0, $urandom_range(0, 31));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
